// File: rtl/mem_arb_pkg.sv
// Shared constants and state encoding for the memory request arbiter.
package mem_arb_pkg;

    localparam int ARB_NREQ = 5;
    localparam int ARB_DW   = 16;

    localparam int REQ_XB    = 0;
    localparam int REQ_FIR   = 1;
    localparam int REQ_AD    = 2;
    localparam int REQ_MOVE  = 3;
    localparam int REQ_UARTO = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after rr_ptr, wrapping at NREQ-1.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = ARB_NREQ,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] pick_oh,
    output logic [IW-1:0]   pick_idx,
    output logic            pick_valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        pick_oh    = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!pick_valid && req[(int'(rr_ptr) + i) % NREQ]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'((int'(rr_ptr) + i) % NREQ);
            end
        end
        if (pick_valid) pick_oh[pick_idx] = 1'b1;
    end

endmodule

// File: rtl/mem_req_arb.sv
// Shared memory channel arbiter: one owner per instruction, released by read_quit.
// Optional idle-owner timeout is compiled in with `define ARB_TIMEOUT_EN.
module mem_req_arb
    import mem_arb_pkg::*;
#(
    parameter int NREQ    = ARB_NREQ,
    parameter int DW      = ARB_DW,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    rd_req_i,
    input  logic [NREQ-1:0]    wr_req_i,
    input  logic [NREQ*DW-1:0] wr_data_i,
    output logic               read,
    output logic               write,
    output logic [DW-1:0]      write_data,
    input  logic               read_ready,
    input  logic               write_ddr_en,
    input  logic               read_quit,
    output logic [NREQ-1:0]    rd_ready_o,
    output logic [NREQ-1:0]    wr_en_o,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic               drop_err,
    output logic               timeout_err,
    input  logic               err_clr
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT must fit the 16-bit idle counter");
    end

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] owner_oh;
    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic            fwd_en;
    logic [IW-1:0]   fwd_idx;
    logic [NREQ-1:0] fwd_oh;
    logic            drop_set;
    logic            timeout_hit;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req        (rd_req_i | wr_req_i),
        .rr_ptr     (rr_ptr_q),
        .pick_oh    (pick_oh),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // Non-owner write strobes while the channel is held are discarded and flagged.
    assign drop_set = (state_q != ST_IDLE) && |(wr_req_i & ~owner_oh);
    assign busy     = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        fwd_en   = 1'b0;
        fwd_idx  = owner_q;
        fwd_oh   = '0;
        unique case (state_q)
            ST_IDLE: begin
                // Gating with reset keeps all outputs low while reset is held.
                if (pick_valid && reset) begin
                    fwd_en   = 1'b1;
                    fwd_idx  = pick_idx;
                    fwd_oh   = pick_oh;
                    owner_d  = pick_idx;
                    rr_ptr_d = pick_idx;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                fwd_en = 1'b1;
                fwd_oh = owner_oh;
                if (read_quit || timeout_hit) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant      = fwd_oh;
        rd_ready_o = '0;
        wr_en_o    = '0;
        read       = 1'b0;
        write      = 1'b0;
        write_data = '0;
        if (fwd_en) begin
            rd_ready_o[fwd_idx] = read_ready;
            wr_en_o[fwd_idx]    = write_ddr_en;
            read                = rd_req_i[fwd_idx];
            write               = wr_req_i[fwd_idx] & write_ddr_en;
            write_data          = wr_data_i[int'(fwd_idx)*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= IW'(NREQ - 1);
            drop_err <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            if (err_clr)       drop_err <= 1'b0;
            else if (drop_set) drop_err <= 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] idle_cnt_q;
    logic        owner_act;

    assign owner_act   = rd_req_i[owner_q] | wr_req_i[owner_q];
    assign timeout_hit = (state_q == ST_GRANT) && !owner_act
                         && (idle_cnt_q == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_q == ST_IDLE || (state_q == ST_GRANT && (owner_act || timeout_hit)))
                idle_cnt_q <= '0;
            else if (state_q == ST_GRANT)
                idle_cnt_q <= idle_cnt_q + 16'd1;
            if (err_clr)                         timeout_err <= 1'b0;
            else if (timeout_hit && !read_quit)  timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_arb.sv
// Randomized + directed bench for mem_req_arb against a cycle-level behavioural model.
module tb_mem_req_arb;
    import mem_arb_pkg::*;

    localparam int NREQ = 5;
    localparam int DW   = 16;
    localparam int TMO  = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    rd_req_i, wr_req_i;
    logic [NREQ*DW-1:0] wr_data_i;
    logic               read, write;
    logic [DW-1:0]      write_data;
    logic               read_ready, write_ddr_en, read_quit, err_clr;
    logic [NREQ-1:0]    rd_ready_o, wr_en_o, grant;
    logic               busy, drop_err, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: channel owned / draining, who owns it, last winner, sticky flags, idle count.
    bit m_owned, m_drain, m_drop, m_tmo;
    int m_owner, m_last, m_cnt;

    always #5 clk = ~clk;

    mem_req_arb #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .rd_req_i(rd_req_i), .wr_req_i(wr_req_i), .wr_data_i(wr_data_i),
        .read(read), .write(write), .write_data(write_data),
        .read_ready(read_ready), .write_ddr_en(write_ddr_en), .read_quit(read_quit),
        .rd_ready_o(rd_ready_o), .wr_en_o(wr_en_o), .grant(grant),
        .busy(busy), .drop_err(drop_err), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_owned = 0; m_drain = 0; m_drop = 0; m_tmo = 0;
        m_owner = 0; m_last = NREQ - 1; m_cnt = 0;
    endfunction

    function automatic int m_pick();
        logic [NREQ-1:0] r;
        r = rd_req_i | wr_req_i;
        for (int i = 1; i <= NREQ; i++)
            if (r[(m_last + i) % NREQ]) return (m_last + i) % NREQ;
        return -1;
    endfunction

    function automatic int m_cur();
        if (!reset) return -1;
        if (m_owned) return m_owner;
        if (m_drain) return -1;
        return m_pick();
    endfunction

    task automatic model_check();
        int c;
        logic [NREQ-1:0] g, rr, we;
        logic er, ew;
        logic [DW-1:0] ed;
        c = m_cur();
        g = '0; rr = '0; we = '0; er = 0; ew = 0; ed = '0;
        if (c >= 0) begin
            g[c] = 1'b1; rr[c] = read_ready; we[c] = write_ddr_en;
            er = rd_req_i[c]; ew = wr_req_i[c] & write_ddr_en;
            ed = wr_data_i[c*DW +: DW];
        end
        check("grant", grant, g);
        check("read", read, er);
        check("write", write, ew);
        check("rd_ready_o", rd_ready_o, rr);
        check("wr_en_o", wr_en_o, we);
        check("busy", busy, reset && (m_owned || m_drain));
        check("drop_err", drop_err, m_drop);
        check("timeout_err", timeout_err, m_tmo);
        if (c < 0 || ew) check("write_data", write_data, ed);
    endtask

    task automatic model_update();
        int w;
        bit hit;
        logic [NREQ-1:0] own_oh;
        if (!reset) begin
            m_reset();
            return;
        end
        w = m_pick();
        hit = 0;
        own_oh = '0;
        own_oh[m_owner] = 1'b1;
        if (err_clr) m_drop = 0;
        else if ((m_owned || m_drain) && (wr_req_i & ~own_oh) != '0) m_drop = 1;
        if (m_owned) begin
            if (read_quit) begin
                m_owned = 0; m_drain = 1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (rd_req_i[m_owner] || wr_req_i[m_owner]) m_cnt = 0;
            else if (m_cnt + 1 == TMO) begin
                hit = 1; m_owned = 0; m_drain = 1; m_cnt = 0;
            end else m_cnt++;
`endif
        end else if (m_drain) begin
            m_drain = 0;
        end else if (w >= 0) begin
            m_owned = 1; m_owner = w; m_last = w; m_cnt = 0;
        end
        if (err_clr) m_tmo = 0;
        else if (hit) m_tmo = 1;
    endtask

    task automatic settle();
        #1 model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic rd_instr(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] exp_g,
                            input string tag);
        rd_req_i = mask;
        settle(); check(tag, grant, exp_g); check({tag, "_read"}, read, 1); tick();
        read_ready = 1;
        settle(); check({tag, "_rdy"}, rd_ready_o, exp_g); tick();
        read_ready = 0; rd_req_i = mask & ~exp_g; read_quit = 1;
        step();
        read_quit = 0; rd_req_i = mask;
        settle(); check({tag, "_drain"}, grant, 0); tick();
    endtask

    task automatic do_reset();
        reset = 0; m_reset();
        step();
        reset = 1;
    endtask

    initial begin
        reset = 0; m_reset();
        rd_req_i = '0; wr_req_i = '0; wr_data_i = '0;
        read_ready = 0; write_ddr_en = 0; read_quit = 0; err_clr = 0;
        @(negedge clk);
        settle(); check("rst_grant", grant, 0); check("rst_busy", busy, 0); tick();
        reset = 1;
        step();

        // Single requester, zero-latency grant, routed read_ready, one DRAIN cycle.
        rd_instr(5'b00100, 5'b00100, "single");
        rd_req_i = '0;
        settle(); check("idle_after_drain", busy, 0); tick();

        // Round-robin from reset: 0, 1, 4, then wrap to 0.
        do_reset();
        rd_instr(5'b10011, 5'b00001, "rr0");
        rd_instr(5'b10011, 5'b00010, "rr1");
        rd_instr(5'b10011, 5'b10000, "rr2");
        rd_instr(5'b10011, 5'b00001, "rr3_wrap");
        rd_req_i = '0;
        step();

        // Owner move writes: stalled, then accepted.
        wr_req_i = 5'b01000; write_ddr_en = 0;
        wr_data_i[REQ_MOVE*DW +: DW] = 16'hA5A5;
        settle(); check("mv_grant", grant, 5'b01000); check("mv_wr_stall", write, 0);
        check("mv_wr_en0", wr_en_o, 0); tick();
        write_ddr_en = 1;
        settle(); check("mv_wr", write, 1); check("mv_data", write_data, 16'hA5A5);
        check("mv_wr_en1", wr_en_o, 5'b01000); tick();
        wr_req_i = '0; read_quit = 1; step();
        read_quit = 0; write_ddr_en = 0; step();

        // Non-owner write while fir owns the channel.
        rd_req_i = 5'b00010; step();
        wr_req_i = 5'b00100; write_ddr_en = 1;
        wr_data_i[REQ_AD*DW +: DW] = 16'h1234;
        settle(); check("drop_write", write, 0); tick();
        wr_req_i = '0; err_clr = 1;
        settle(); check("drop_set", drop_err, 1); tick();
        err_clr = 0; rd_req_i = '0; read_quit = 1;
        settle(); check("drop_clr", drop_err, 0); tick();
        read_quit = 0; write_ddr_en = 0; step();

        // Reset in the middle of GRANT for owner xb.
        rd_req_i = 5'b00001; step();
        settle();
        #2 reset = 0; m_reset();
        #1 check("mrst_grant", grant, 0); check("mrst_read", read, 0); check("mrst_busy", busy, 0);
        tick();
        reset = 1; rd_req_i = 5'b10001;
        settle(); check("post_rst_grant", grant, 5'b00001); tick();
        rd_req_i = '0; read_quit = 1; step();
        read_quit = 0; step();

        // Owner uarto goes idle after its read.
        rd_req_i = 5'b10000; step();
        read_ready = 1; step();
        read_ready = 0; rd_req_i = '0;
        repeat (TMO) step();
        settle();
`ifdef ARB_TIMEOUT_EN
        check("tmo_err", timeout_err, 1); check("tmo_grant", grant, 0);
`else
        check("tmo_err", timeout_err, 0); check("tmo_grant", grant, 5'b10000);
`endif
        tick();
        repeat (20) step();
        read_quit = 1; step();
        read_quit = 0; err_clr = 1; step();
        err_clr = 0; step();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            int w;
            rd_req_i     = NREQ'($urandom);
            wr_req_i     = NREQ'($urandom & $urandom);
            write_ddr_en = 1'($urandom_range(0, 1));
            read_ready   = 1'($urandom_range(0, 1));
            read_quit    = ($urandom_range(0, 7) == 0);
            err_clr      = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NREQ; k++) wr_data_i[k*DW +: DW] = 16'($urandom);
            if (!m_owned && !m_drain) begin
                w = m_pick();
                wr_req_i = (w >= 0) ? (wr_req_i & (NREQ'(1) << w)) : '0;
            end
            if (m_drain) wr_req_i[m_owner] = 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
